muldiv_unit: RTL and testbench

Iterative 16-bit unsigned multiply/divide unit in the execute stage. It consumes the two operands read from the register file (rs, rt) and writes its result back through the register-file write port (rd, selRd, wen). Multi-cycle: the control unit stalls on busy and releases on done.

---
 rtl/muldiv_unit_pkg.sv | 24 ++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared CPU definitions for the execute-stage multiply/divide unit:
//   operation encodings, FSM state encodings and the datapath / register-select
//   widths that are common with the register file.
package muldiv_unit_pkg;

    localparam int WIDTH_DEF = 16;  // operand / result width
    localparam int SEL_W_DEF = 4;   // 16 architectural registers
    localparam int CNT_W_DEF = 4;   // clog2(WIDTH_DEF)

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,  // product[WIDTH-1:0]
        OP_MULH = 2'b01,  // product[2*WIDTH-1:WIDTH]
        OP_DIV  = 2'b10,  // quotient
        OP_REM  = 2'b11   // remainder
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative unsigned multiply/divide unit. Shift-add multiply and restoring
//   divide share one 2*WIDTH accumulator and run one iteration per clock.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    request, sampled only in IDLE
//   op       00 MUL, 01 MULH, 10 DIV, 11 REM
//   selDst   destination register index, captured with start
//   rs, rt   multiplicand/dividend, multiplier/divisor (captured with start)
//   busy     operation in flight (RUN or DONE)
//   done     one-cycle completion pulse
//   divZero  with done: DIV/REM had rt == 0
//   wen      register-file write enable (same as done)
//   selRd    register-file write index, valid with wen
//   rd       register-file write data, valid with wen
//
// Handshake: start is accepted only when busy is low (state IDLE); the unit
// then holds busy high until and including the single cycle in which
// done/wen pulse. A start seen while busy is dropped, never queued.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SEL_W-1:0] selDst,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic             wen,
    output logic [SEL_W-1:0] selRd,
    output logic [WIDTH-1:0] rd
);

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    op_e                r_op;
    logic [SEL_W-1:0]   r_sel;
    logic [WIDTH-1:0]   r_b;      // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] r_acc;    // MUL: {partial, multiplier}; DIV: {rem, quot}

    logic               r_busy, r_done, r_divzero;
    logic [SEL_W-1:0]   r_sel_rd;
    logic [WIDTH-1:0]   r_rd;

    logic               w_div0;
    logic               w_last;
    logic [WIDTH:0]     w_add_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_acc_step;
    logic               w_divzero_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [WIDTH-1:0]   w_rd_nxt;

    assign w_div0 = op[1] && (rt == '0);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // One iteration of either algorithm. The multiply add is WIDTH+1 bits so
    // its carry shifts into the accumulator MSB. The divide compare is also
    // WIDTH+1 bits: the shifted remainder can reach 2*divisor-1.
    assign w_add_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial   = w_rem_sh - {1'b0, r_b};

    always_comb begin
        w_acc_step = r_acc;
        if (!r_op[1]) begin
            if (r_acc[0]) w_acc_step = {w_add_sum, r_acc[WIDTH-1:1]};
            else          w_acc_step = {1'b0, r_acc[2*WIDTH-1:1]};
        end else begin
            if (w_trial[WIDTH]) w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
            else                w_acc_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = w_div0 ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: values the registered outputs take on entering DONE.
    always_comb begin
        w_divzero_nxt = 1'b0;
        w_sel_nxt     = '0;
        w_rd_nxt      = '0;
        if (r_state == S_IDLE && start && w_div0) begin
            w_divzero_nxt = 1'b1;
            w_sel_nxt     = selDst;
            w_rd_nxt      = (op_e'(op) == OP_DIV) ? '1 : rs;
        end else if (r_state == S_RUN && w_last) begin
            w_sel_nxt = r_sel;
            case (r_op)
                OP_MUL:  w_rd_nxt = w_acc_step[WIDTH-1:0];
                OP_MULH: w_rd_nxt = w_acc_step[2*WIDTH-1:WIDTH];
                OP_DIV:  w_rd_nxt = w_acc_step[WIDTH-1:0];
                OP_REM:  w_rd_nxt = w_acc_step[2*WIDTH-1:WIDTH];
                default: w_rd_nxt = '0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_op  <= OP_MUL;
            r_sel <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_cnt <= '0;
            r_op  <= op_e'(op);
            r_sel <= selDst;
            r_b   <= op[1] ? rt : rs;
            r_acc <= {{WIDTH{1'b0}}, (op[1] ? rs : rt)};
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_step;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            r_sel_rd  <= '0;
            r_rd      <= '0;
        end else begin
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_divzero <= w_divzero_nxt;
            r_sel_rd  <= w_sel_nxt;
            r_rd      <= w_rd_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign wen     = r_done;
    assign divZero = r_divzero;
    assign selRd   = r_sel_rd;
    assign rd      = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Bench for muldiv_unit: directed test-plan cases plus random operations.
//   Expected writes {divZero, selRd, rd} are queued when a start is driven and
//   compared whenever the unit raises wen.
module tb_muldiv_unit;

  localparam int W   = 16;
  localparam int SW  = 4;
  localparam int EW  = 1 + SW + W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [SW-1:0] selDst;
  logic [W-1:0]  rs, rt;
  logic          busy, done, divZero, wen;
  logic [SW-1:0] selRd;
  logic [W-1:0]  rd;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_wen    = 0;

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .selDst  (selDst),
    .rs      (rs),
    .rt      (rt),
    .busy    (busy),
    .done    (done),
    .divZero (divZero),
    .wen     (wen),
    .selRd   (selRd),
    .rd      (rd)
  );

  // ---------------------------------------------------------------- checking
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference results computed from plain arithmetic.
  function automatic logic [W-1:0] model_rd(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (done || wen) begin
        check_val("done_eq_wen", {31'b0, wen}, {31'b0, done});
        n_wen++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_wen", 32'd1, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check_val("rd",      {16'b0, rd},          {16'b0, e[W-1:0]});
          check_val("selRd",   {28'b0, selRd},       {28'b0, e[W+SW-1:W]});
          check_val("divZero", {31'b0, divZero},     {31'b0, e[EW-1]});
          check_val("busy_in_done", {31'b0, busy},   32'd1);
        end
      end else begin
        check_val("idle_outputs", {11'b0, divZero, selRd, rd}, 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Starts one operation, scrambles the operand inputs after the start edge,
  // then measures latency and busy length from the cycle after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] s);
    int lat, busy_cnt, exp_lat;
    bit seen;
    logic dz;
    dz      = o[1] && (b == 0);
    exp_lat = dz ? 1 : 17;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs = a; rt = b; selDst = s;
    exp_q.push_back({dz, s, model_rd(o, a, b)});
    @(posedge clk); #1;
    start = 1'b0;
    rs = W'($urandom); rt = W'($urandom); selDst = SW'($urandom); op = 2'($urandom);
    lat = 0; busy_cnt = 0; seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        lat  = k;
      end
    end
    if (!seen) check_val("timeout", 32'd0, 32'd1);
    else begin
      check_val("latency", lat, exp_lat);
      check_val("busy_len", busy_cnt, exp_lat);
      @(negedge clk);
      check_val("done_pulse", {30'b0, busy, done}, 32'd0);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int k = 0; k < max_cycles && busy; k++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int wen0;
    rst = 1'b0; start = 1'b0; op = 2'b00; selDst = '0; rs = '0; rt = '0;
    #23;
    check_val("reset_outputs", {10'b0, busy, done, wen, divZero, selRd, rd}, 32'd0);
    #4 rst = 1'b1;

    // 1: MUL 300*200
    do_op(2'b00, 16'd300, 16'd200, 4'd3);
    // 2: MULH / MUL of all-ones
    do_op(2'b01, 16'hFFFF, 16'hFFFF, 4'd1);
    do_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd2);
    // 3: DIV / REM
    do_op(2'b10, 16'd1000, 16'd7, 4'd9);
    do_op(2'b11, 16'd1000, 16'd7, 4'd9);
    do_op(2'b10, 16'd5, 16'd9, 4'd0);
    // 4: divide by zero
    do_op(2'b10, 16'd1234, 16'd0, 4'd4);
    do_op(2'b11, 16'd1234, 16'd0, 4'd5);

    // 5: start while busy is ignored
    wen0 = n_wen;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs = 16'd3; rt = 16'd4; selDst = 4'd6;
    exp_q.push_back({1'b0, 4'd6, 16'd12});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b10; rs = 16'd100; rt = 16'd10; selDst = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(40);
    repeat (25) @(negedge clk);
    check_val("ignored_start_wen_count", n_wen - wen0, 32'd1);
    do_op(2'b10, 16'd100, 16'd10, 4'd7);

    // 6: reset mid-operation aborts with no write
    wen0 = n_wen;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; rs = 16'd300; rt = 16'd200; selDst = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_val("async_reset", {10'b0, busy, done, wen, divZero, selRd, rd}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    check_val("abort_no_wen", n_wen - wen0, 32'd0);
    do_op(2'b00, 16'd2, 16'd3, 4'd10);

    // Random operations, including zero and small divisors
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      int sel_b;
      a     = W'($urandom);
      sel_b = $urandom_range(0, 3);
      b     = (sel_b == 0) ? '0 : (sel_b == 1) ? W'($urandom_range(1, 15)) : W'($urandom);
      do_op(2'($urandom_range(0, 3)), a, b, SW'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
